// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch stage. Holds the PC, issues word reads
//                over a req/gnt/rvalid bus, buffers returned words in a
//                prefetch FIFO and hands them to the core with valid/ready.
//                Redirects flush the FIFO and drain in-flight responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    output logic        o_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W:0]   c_DEPTH    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
    localparam logic [0:0]       c_ST_FETCH = 1'b0;
    localparam logic [0:0]       c_ST_DRAIN = 1'b1;

    // Registered state
    logic [0:0]       r_state;
    logic [31:0]      r_pc;          // next address to request
    logic [31:0]      r_resp_pc;     // PC belonging to the next response to arrive
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic             r_err;
    logic [31:0]      r_data_mem [FIFO_DEPTH];
    logic [31:0]      r_pc_mem   [FIFO_DEPTH];

    // Combinational control
    logic             w_credit;
    logic             w_req;
    logic             w_accept;
    logic             w_resp_ok;
    logic             w_spurious;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_valid;
    logic [31:0]      w_redirect_pc;
    logic [CNT_W-1:0] w_out_next;
    logic [0:0]       w_state_next;
    logic             w_unused_pc_lsbs;

    // Low address bits of a redirect target carry no information.
    assign w_unused_pc_lsbs = &{1'b1, i_redirect_pc[1:0]};
    assign w_redirect_pc    = {i_redirect_pc[31:2], 2'b00};

    // A slot must exist for every word that can come back; a same-cycle pop
    // is deliberately not counted as a free slot.
    assign w_credit     = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH;
    assign w_req        = rst && (r_state == c_ST_FETCH) && !i_redirect && w_credit;
    assign w_accept     = w_req && i_mem_gnt;
    assign w_resp_ok    = i_mem_rvalid && (r_outstanding != '0);
    assign w_spurious   = i_mem_rvalid && (r_outstanding == '0);
    assign w_push       = w_resp_ok && (r_state == c_ST_FETCH) && !i_redirect;
    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = w_fifo_valid && i_instr_ready;

    assign o_mem_req     = w_req;
    assign o_mem_addr    = r_pc;
    assign o_instr_valid = w_fifo_valid;
    assign o_instr       = w_fifo_valid ? r_data_mem[r_rd_ptr] : NOP_INSTR;
    assign o_instr_pc    = w_fifo_valid ? r_pc_mem[r_rd_ptr]   : 32'h0000_0000;
    assign o_err         = r_err;

    // Outstanding-count update and FETCH/DRAIN next-state decision.
    always_comb begin
        w_out_next   = r_outstanding;
        w_state_next = r_state;
        case ({w_accept, w_resp_ok})
            2'b10:   w_out_next = r_outstanding + c_CNT_ONE;
            2'b01:   w_out_next = r_outstanding - c_CNT_ONE;
            default: w_out_next = r_outstanding;
        endcase
        // After a redirect, stale responses must be swallowed before refetching.
        if (i_redirect || (r_state == c_ST_DRAIN)) begin
            w_state_next = (w_out_next != '0) ? c_ST_DRAIN : c_ST_FETCH;
        end
    end

    // PC, credit, FIFO pointer and error-flag registers.
    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_ST_FETCH;
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_out_next;
            if (w_spurious) begin
                r_err <= 1'b1;
            end
            if (i_redirect) begin
                r_pc      <= w_redirect_pc;
                r_resp_pc <= w_redirect_pc;
                r_count   <= '0;
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + c_PTR_ONE;
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage: instruction word and its PC, written on accepted responses.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= i_mem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit with a queue-based
//                fetch model and an in-order memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;
    logic        o_err;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_dut (
        .i_clk         (i_clk),
        .rst           (rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_gnt     (i_mem_gnt),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_instr_ready (i_instr_ready),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: fetch stage seen as queues of in-flight and buffered words
    logic [31:0] m_pc;
    logic [31:0] m_inflight[$];
    logic [31:0] m_fifo_d[$];
    logic [31:0] m_fifo_pc[$];
    bit          m_drain;
    bit          m_err;

    // Memory model: accepted addresses with the cycle their response is due
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          last_due;
    int          cyc;
    int          lat_min = 1;
    int          lat_max = 1;

    // Outputs observed in the most recent cycle
    logic        obs_req, obs_valid, obs_err;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_clear();
        m_pc = RESET_PC;
        m_inflight.delete();
        m_fifo_d.delete();
        m_fifo_pc.delete();
        m_drain = 1'b0;
        m_err = 1'b0;
        mem_addr_q.delete();
        mem_due_q.delete();
        last_due = -100;
        cyc = 0;
    endtask

    // Asynchronous reset in mid-cycle; outputs must take reset values at once.
    task automatic do_reset();
        @(negedge i_clk);
        #2;
        rst = 1'b0;
        i_redirect = 1'b0;
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b0;
        i_instr_ready = 1'b0;
        #1;
        check("rst_req",   {31'd0, o_mem_req},     32'd0);
        check("rst_addr",  o_mem_addr,             RESET_PC);
        check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        check("rst_instr", o_instr,                NOP_INSTR);
        check("rst_pc",    o_instr_pc,             32'd0);
        check("rst_err",   {31'd0, o_err},         32'd0);
        repeat (2) @(negedge i_clk);
        model_clear();
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance both models.
    task automatic run_cycle(input bit redir, input logic [31:0] rpc, input bit gnt,
                             input bit rdy, input bit spur);
        logic        rv;
        logic [31:0] rd;
        logic [31:0] p;
        bit          m_req, m_valid, acc;
        int          due;
        @(negedge i_clk);
        rv = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
        rd = rv ? mem_word(mem_addr_q[0]) : $urandom;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_mem_gnt     = gnt;
        i_mem_rvalid  = rv | spur;
        i_mem_rdata   = rd;
        i_instr_ready = rdy;
        #1;
        m_req   = !m_drain && !redir && ((m_inflight.size() + m_fifo_pc.size()) < FIFO_DEPTH);
        m_valid = (m_fifo_pc.size() > 0);
        check("mem_req",     {31'd0, o_mem_req},     {31'd0, m_req});
        check("mem_addr",    o_mem_addr,             m_pc);
        check("instr_valid", {31'd0, o_instr_valid}, {31'd0, m_valid});
        check("instr",       o_instr,                m_valid ? m_fifo_d[0] : NOP_INSTR);
        check("instr_pc",    o_instr_pc,             m_valid ? m_fifo_pc[0] : 32'd0);
        check("err",         {31'd0, o_err},         {31'd0, m_err});
        obs_req = o_mem_req; obs_addr = o_mem_addr; obs_valid = o_instr_valid;
        obs_instr = o_instr; obs_pc = o_instr_pc; obs_err = o_err;

        acc = m_req && gnt;
        if (m_valid && rdy) begin
            void'(m_fifo_d.pop_front());
            void'(m_fifo_pc.pop_front());
        end
        if (rv || spur) begin
            if (m_inflight.size() == 0) begin
                m_err = 1'b1;
            end else begin
                p = m_inflight.pop_front();
                if (!m_drain && !redir) begin
                    m_fifo_d.push_back(rd);
                    m_fifo_pc.push_back(p);
                end
            end
        end
        if (acc) begin
            m_inflight.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_fifo_d.delete();
            m_fifo_pc.delete();
            m_pc = {rpc[31:2], 2'b00};
        end
        if (redir || m_drain) m_drain = (m_inflight.size() > 0);

        if (rv) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            mem_addr_q.push_back(m_inflight[m_inflight.size()-1]);
            mem_due_q.push_back(due);
            last_due = due;
        end
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  nacc;
        int  wait_n;
        bit  found;
        bit  saw_valid;
        model_clear();

        // Streaming with single-cycle memory and an always-ready core
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            check("t1_req",  {31'd0, obs_req}, 32'd1);
            check("t1_addr", obs_addr, 32'(i * 4));
            if (i >= 2) begin
                check("t1_valid", {31'd0, obs_valid}, 32'd1);
                check("t1_pc",    obs_pc, 32'((i - 2) * 4));
            end else begin
                check("t1_valid_early", {31'd0, obs_valid}, 32'd0);
            end
        end

        // Stalled core: credits stop fetching at FIFO_DEPTH words
        do_reset();
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (obs_req) nacc++;
        end
        check("t2_accepts", 32'(nacc), 32'd4);
        check("t2_req_off", {31'd0, obs_req}, 32'd0);
        check("t2_head",    obs_pc, 32'd0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t2_pop0", obs_pc, 32'h0);
        check("t2_pop_not_credited", {31'd0, obs_req}, 32'd0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t2_pop1", obs_pc, 32'h4);
        check("t2_refetch_req",  {31'd0, obs_req}, 32'd1);
        check("t2_refetch_addr", obs_addr, 32'h10);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t2_pop2", obs_pc, 32'h8);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t2_pop3", obs_pc, 32'hC);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t2_pop4", obs_pc, 32'h10);

        // Grant withheld: address holds until accepted
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            check("t3_req_held",  {31'd0, obs_req}, 32'd1);
            check("t3_addr_held", obs_addr, RESET_PC);
        end
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t3_addr_gnt", obs_addr, RESET_PC);
        run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check("t3_addr_next", obs_addr, RESET_PC + 32'd4);

        // Redirect with two responses in flight and two words buffered
        do_reset();
        lat_min = 1; lat_max = 1;
        run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        lat_min = 5; lat_max = 5;
        run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        lat_min = 1; lat_max = 1;
        check("t4_setup_inflight", 32'(m_inflight.size()), 32'd2);
        run_cycle(1'b1, 32'h0000_1003, 1'b1, 1'b0, 1'b0);
        check("t4_setup_valid", {31'd0, obs_valid}, 32'd1);
        check("t4_redirect_req", {31'd0, obs_req}, 32'd0);
        found = 1'b0; saw_valid = 1'b0; wait_n = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            if (obs_valid) saw_valid = 1'b1;
            if (obs_req) begin
                found = 1'b1;
                wait_n = i;
            end
        end
        check("t4_refetch_req",  {31'd0, found}, 32'd1);
        check("t4_refetch_addr", obs_addr, 32'h0000_1000);
        check("t4_drain_cycles", 32'(wait_n), 32'd4);
        check("t4_no_stale",     {31'd0, saw_valid}, 32'd0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("t4_new_head_pc",    obs_pc, 32'h0000_1000);
        check("t4_new_head_instr", obs_instr, mem_word(32'h0000_1000));

        // Redirect coinciding with a response and a pop
        do_reset();
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
        check("t5_popped_pc",  obs_pc, 32'd0);
        check("t5_rvalid_on",  {31'd0, i_mem_rvalid}, 32'd1);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t5_valid", {31'd0, obs_valid}, 32'd0);
        check("t5_instr", obs_instr, 32'h0000_0013);
        check("t5_addr",  obs_addr, 32'h0000_0200);

        // PC wrap at the top of the address space, then a spurious response
        do_reset();
        run_cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t6_addr0", obs_addr, 32'hFFFF_FFF8);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t6_addr1", obs_addr, 32'hFFFF_FFFC);
        run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check("t6_addr2", obs_addr, 32'h0000_0000);
        for (int i = 0; i < 10 && mem_addr_q.size() > 0; i++) begin
            run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        end
        check("t6_err_before", {31'd0, obs_err}, 32'd0);
        run_cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            check("t6_err_sticky", {31'd0, obs_err}, 32'd1);
        end
        do_reset();

        // Randomized traffic against the model, with one mid-stream reset
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            bit          redir, spur;
            if (i == 1500) do_reset();
            redir = ($urandom_range(99) < 4);
            rpc   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            spur  = (mem_addr_q.size() == 0) && ($urandom_range(499) == 0);
            run_cycle(redir, rpc, ($urandom_range(99) < 70), ($urandom_range(99) < 60), spur);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of RISC_V_Processor. It holds the PC, issues word reads to instruction memory over a req/gnt/rvalid bus, buffers returned words in a small prefetch FIFO, and presents them to the processor's i_instr input with a valid/ready handshake. On a redirect (branch/jump/trap) it flushes the buffered words and refetches from a new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset release.
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, 2..16); also caps outstanding requests.
NOP_INSTR, 32'h0000_0013, value driven on o_instr while FIFO empty.

Ports:
i_clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
i_redirect  input  1  redirect strobe, one cycle.
i_redirect_pc  input  32  new PC; bits [1:0] are ignored and forced to 0.
o_mem_req  output  1  memory read request.
o_mem_addr  output  32  word-aligned request address.
i_mem_gnt  input  1  request accepted when o_mem_req && i_mem_gnt.
i_mem_rvalid  input  1  read data valid; responses return in order, latency >= 1.
i_mem_rdata  input  32  read data.
o_instr_valid  output  1  FIFO head valid.
o_instr  output  32  FIFO head instruction (NOP_INSTR when empty); feeds processor i_instr.
o_instr_pc  output  32  PC of FIFO head (0 when empty).
i_instr_ready  input  1  processor accepts head when o_instr_valid && i_instr_ready.
o_err  output  1  sticky: rvalid received with zero outstanding.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, FIFO empty, outstanding=0, state=FETCH, o_mem_req=0, o_mem_addr=RESET_PC, o_instr_valid=0, o_instr=NOP_INSTR, o_instr_pc=0, o_err=0.
- Credits: outstanding (0..FIFO_DEPTH) + fifo_count must be < FIFO_DEPTH to request; pop in the same cycle is not credited (conservative).
- o_mem_req is combinational: state==FETCH && !i_redirect && credit available. o_mem_addr=pc.
- Accepted request: pc <= pc+4, wrapping 32'hFFFF_FFFC -> 0; outstanding++.
- Response (i_mem_rvalid): outstanding--. In FETCH without redirect, push {rdata, addr}. Each response's PC is tracked by a parallel address queue or pc-of-tail register. Data is visible at o_instr the cycle after rvalid.
- Simultaneous accept and response: outstanding unchanged.
- Pop when o_instr_valid && i_instr_ready. Simultaneous push/pop on a full FIFO cannot occur because of credits.
- States:
  - FETCH: normal operation.
  - On i_redirect: FIFO flushed, pc <= {i_redirect_pc[31:2],2'b00}. A response arriving in the redirect cycle is discarded. If outstanding after this cycle > 0, go to DRAIN; else stay in FETCH, and the new-PC request may assert next cycle.
  - DRAIN: o_mem_req=0. Every response is discarded (outstanding--). When outstanding reaches 0, go to FETCH.
  - Redirect in DRAIN updates pc only (last one wins).
- Redirect and pop in the same cycle: the handshake counts as consumed by the processor; the FIFO is still cleared.
- rvalid with outstanding==0: ignored, o_err <= 1 until reset.
- Reset asserted mid-transaction: everything returns to reset state immediately; stale responses after reset release set o_err (system contract: memory is reset together with this block).

Test Plan:
- Reset release, 1-cycle memory (gnt=1, rvalid the cycle after accept), ready=1. Required: addresses 0,4,8,… each cycle; first o_instr_valid 2 cycles after first accept; o_instr_pc sequence 0,4,8.
- ready=0, FIFO_DEPTH=4. Required: exactly 4 requests accepted, then o_mem_req=0. FIFO holds PCs 0..C. Raising ready drains in order and refetching resumes at 0x10.
- gnt held low 3 cycles. Required: o_mem_req stays 1 with o_mem_addr stable at RESET_PC; pc advances only after gnt.
- Redirect to 0x1003 with 2 outstanding and 2 buffered entries. Required: valid drops next cycle; both late responses discarded (DRAIN); next request address is 0x1000.
- Redirect in the same cycle as an rvalid and a pop. Required: the response is not delivered, FIFO empty, o_instr=0x00000013.
- PC at 0xFFFF_FFF8: required fetch addresses FFF8, FFFC, 0x0000_0000. Spurious rvalid with 0 outstanding: required o_err=1 and sticky until rst=0.
